// File: rtl/ai_mc_pkg.sv
// Shared types and defaults for the memory-controller command arbiter.
// Provides the arbiter FSM state type and the default burst geometry.
package ai_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } arb_state_t;

    localparam int DEF_LEN_W       = 16;
    localparam int DEF_MAX_BURST   = 16;
    localparam int DEF_BOUND_BEATS = 256;

    typedef logic [DEF_LEN_W-1:0] beat_len_t;
    typedef logic [DEF_LEN_W:0]   beat_len_ext_t;

endpackage

// File: rtl/ai_mc_rr_arb.sv
// Combinational round-robin picker: first valid at or after ptr (wrapping).
// Ports: valid/ptr in; grant (one-hot), idx, any out.
module ai_mc_rr_arb
    import ai_mc_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin : pick
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/ai_mc_cmd_arb.sv
// Round-robin command scheduler splitting client requests into bounded bursts.
// Ports: req_* client side, rd_cmd_*/wr_cmd_*/done burst side, status outputs.
module ai_mc_cmd_arb
    import ai_mc_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 16,
    parameter int MAX_BURST   = DEF_MAX_BURST,
    parameter int BOUND_BEATS = DEF_BOUND_BEATS,
    parameter int TIMEOUT     = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    output logic [NUM_REQ-1:0]          req_done,
    output logic                        req_err,
    output logic                        rd_cmd_valid,
    input  logic                        rd_cmd_ready,
    output logic [ADDR_W-1:0]           rd_cmd_addr,
    output logic [LEN_W-1:0]            rd_cmd_len,
    output logic                        wr_cmd_valid,
    input  logic                        wr_cmd_ready,
    output logic [ADDR_W-1:0]           wr_cmd_addr,
    output logic [LEN_W-1:0]            wr_cmd_len,
    input  logic                        rd_done,
    input  logic                        wr_done,
    output logic [$clog2(NUM_REQ)-1:0]  owner_id,
    output logic                        busy,
    output logic                        arb_error
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT) + 1;

    arb_state_t          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    owner;
    logic                wr_q;
    logic [ADDR_W-1:0]   cur_addr;
    logic [LEN_W-1:0]    remaining;
    logic [WD_W-1:0]     wdog;
    logic                err_flag;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    gidx;
    logic                gany;
    logic [ADDR_W-1:0]   sel_addr;
    logic [LEN_W-1:0]    sel_len;

    logic [ADDR_W-1:0]   off;
    logic [LEN_W:0]      room;
    logic [LEN_W:0]      lim;
    logic [LEN_W-1:0]    chunk;
    logic                cmd_hs;
    logic                done_sel;

    ai_mc_rr_arb #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign sel_addr = req_addr[int'(gidx)*ADDR_W +: ADDR_W];
    assign sel_len  = req_len[int'(gidx)*LEN_W +: LEN_W];

    // Burst size: remaining, MAX_BURST and room left before the boundary.
    // Extra bit keeps BOUND_BEATS - offset from overflowing LEN_W.
    always_comb begin
        off  = cur_addr & ADDR_W'(BOUND_BEATS - 1);
        room = (LEN_W+1)'(BOUND_BEATS) - (LEN_W+1)'(off);
        lim  = (LEN_W+1)'(MAX_BURST);
        if ({1'b0, remaining} < lim) lim = {1'b0, remaining};
        if (room < lim) lim = room;
        chunk = LEN_W'(lim);
    end

    assign cmd_hs   = wr_q ? wr_cmd_ready : rd_cmd_ready;
    assign done_sel = wr_q ? wr_done : rd_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            wr_q      <= 1'b0;
            cur_addr  <= '0;
            remaining <= '0;
            wdog      <= '0;
            err_flag  <= 1'b0;
            arb_error <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (gany) begin
                        owner     <= gidx;
                        wr_q      <= req_write[gidx];
                        cur_addr  <= sel_addr;
                        remaining <= sel_len;
                        rr_ptr    <= (gidx == IDX_W'(NUM_REQ - 1)) ?
                                     '0 : gidx + 1'b1;
                        state     <= (sel_len == '0) ? ST_FINISH : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_hs) begin
                        cur_addr  <= cur_addr + ADDR_W'(chunk);
                        remaining <= remaining - chunk;
                        wdog      <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A done arriving on the last watchdog cycle still counts.
                    if (done_sel) begin
                        state <= (remaining == '0) ? ST_FINISH : ST_ISSUE;
                    end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                        arb_error <= 1'b1;
                        err_flag  <= 1'b1;
                        state     <= ST_FINISH;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                ST_FINISH: begin
                    err_flag <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Grant is combinational; masked by rst so reset shows all-zero outputs.
    assign req_ready = (state == ST_IDLE && !rst) ? grant : '0;

    assign rd_cmd_valid = (state == ST_ISSUE) && !wr_q;
    assign rd_cmd_addr  = rd_cmd_valid ? cur_addr : '0;
    assign rd_cmd_len   = rd_cmd_valid ? chunk : '0;
    assign wr_cmd_valid = (state == ST_ISSUE) && wr_q;
    assign wr_cmd_addr  = wr_cmd_valid ? cur_addr : '0;
    assign wr_cmd_len   = wr_cmd_valid ? chunk : '0;

    assign req_done = (state == ST_FINISH) ? (NUM_REQ'(1) << owner) : '0;
    assign req_err  = (state == ST_FINISH) && err_flag;
    assign owner_id = owner;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_ai_mc_cmd_arb.sv
// Directed bench for ai_mc_cmd_arb: table of single requests plus
// hand-written sequences for timeout, reset and round-robin order.
module tb_ai_mc_cmd_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int TO = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_write, req_done;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_len;
    logic            req_err;
    logic            rd_cmd_valid, rd_cmd_ready;
    logic [AW-1:0]   rd_cmd_addr;
    logic [LW-1:0]   rd_cmd_len;
    logic            wr_cmd_valid, wr_cmd_ready;
    logic [AW-1:0]   wr_cmd_addr;
    logic [LW-1:0]   wr_cmd_len;
    logic            rd_done, wr_done;
    logic [1:0]      owner_id;
    logic            busy, arb_error;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    ai_mc_cmd_arb #(
        .NUM_REQ(N), .ADDR_W(AW), .LEN_W(LW),
        .MAX_BURST(16), .BOUND_BEATS(256), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_done(req_done), .req_err(req_err),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
        .rd_cmd_addr(rd_cmd_addr), .rd_cmd_len(rd_cmd_len),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
        .wr_cmd_addr(wr_cmd_addr), .wr_cmd_len(wr_cmd_len),
        .rd_done(rd_done), .wr_done(wr_done),
        .owner_id(owner_id), .busy(busy), .arb_error(arb_error)
    );

    typedef struct {
        int          c;
        bit          wr;
        logic [31:0] addr;
        logic [15:0] len;
        int          first;
        int          nb;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] b_addr[8];
    logic [15:0] b_len[8];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int c, input bit wr,
                             input logic [31:0] a, input logic [15:0] l);
        req_valid             = '0;
        req_valid[c]          = 1'b1;
        req_write[c]          = wr;
        req_addr[c*AW +: AW]  = a;
        req_len[c*LW +: LW]   = l;
    endtask

    task automatic run_vec(input vec_t v);
        int e;
        drive_req(v.c, v.wr, v.addr, v.len);
        #1;
        chk("grant", 64'(req_ready), 64'(1 << v.c));
        step();
        req_valid = '0;
        #1;
        chk("owner_id", 64'(owner_id), 64'(v.c));
        for (int b = 0; b < v.nb; b++) begin
            e = v.first + b;
            for (int s = 0; s < 2; s++) begin
                chk("cmd_valid", v.wr ? wr_cmd_valid : rd_cmd_valid, 1);
                chk("other_valid", v.wr ? rd_cmd_valid : wr_cmd_valid, 0);
                chk("cmd_addr", v.wr ? wr_cmd_addr : rd_cmd_addr, b_addr[e]);
                chk("cmd_len", v.wr ? wr_cmd_len : rd_cmd_len, b_len[e]);
                if (s == 0) step();
            end
            if (v.wr) wr_cmd_ready = 1'b1;
            else rd_cmd_ready = 1'b1;
            step();
            wr_cmd_ready = 1'b0;
            rd_cmd_ready = 1'b0;
            if (v.wr) rd_done = 1'b1;
            else wr_done = 1'b1;
            step();
            rd_done = 1'b0;
            wr_done = 1'b0;
            #1;
            chk("wait_hold", 64'({busy, rd_cmd_valid, wr_cmd_valid, req_done}),
                64'({1'b1, 1'b0, 1'b0, 4'b0}));
            if (v.wr) wr_done = 1'b1;
            else rd_done = 1'b1;
            step();
            rd_done = 1'b0;
            wr_done = 1'b0;
            #1;
            if (b != v.nb - 1) chk("no_early_done", 64'(req_done), 0);
        end
        chk("req_done", 64'(req_done), 64'(1 << v.c));
        chk("req_err", req_err, 0);
        chk("no_cmd_in_finish", 64'({rd_cmd_valid, wr_cmd_valid}), 0);
        step();
        chk("idle_after", 64'({busy, req_done}), 0);
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        rd_cmd_ready = 1'b0; wr_cmd_ready = 1'b0;
        rd_done = 1'b0; wr_done = 1'b0;

        b_addr[0] = 32'h10;       b_len[0] = 16'd8;
        b_addr[1] = 32'hF8;       b_len[1] = 16'd8;
        b_addr[2] = 32'h100;      b_len[2] = 16'd16;
        b_addr[3] = 32'h110;      b_len[3] = 16'd16;
        b_addr[4] = 32'hFFFFFFFE; b_len[4] = 16'd2;
        b_addr[5] = 32'h0;        b_len[5] = 16'd3;
        b_addr[6] = 32'h3;        b_len[6] = 16'd16;
        b_addr[7] = 32'h13;       b_len[7] = 16'd16;

        vecs[0] = '{c: 0, wr: 1'b0, addr: 32'h10,       len: 16'd8,  first: 0, nb: 1};
        vecs[1] = '{c: 2, wr: 1'b1, addr: 32'hF8,       len: 16'd40, first: 1, nb: 3};
        vecs[2] = '{c: 1, wr: 1'b0, addr: 32'h55,       len: 16'd0,  first: 0, nb: 0};
        vecs[3] = '{c: 3, wr: 1'b0, addr: 32'hFFFFFFFE, len: 16'd5,  first: 4, nb: 2};
        vecs[4] = '{c: 1, wr: 1'b1, addr: 32'h3,        len: 16'd32, first: 6, nb: 2};

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_cmds", 64'({rd_cmd_valid, wr_cmd_valid}), 0);
        chk("rst_misc", 64'({req_ready, req_done, req_err, arb_error, owner_id}), 0);
        step();
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Done in the last watchdog cycle beats the timeout.
        drive_req(3, 1'b0, 32'h0, 16'd2);
        step();
        req_valid = '0;
        rd_cmd_ready = 1'b1;
        step();
        rd_cmd_ready = 1'b0;
        repeat (TO - 1) step();
        rd_done = 1'b1;
        #1;
        chk("edge_still_wait", 64'({busy, req_done}), 64'({1'b1, 4'b0}));
        step();
        rd_done = 1'b0;
        #1;
        chk("edge_done", 64'(req_done), 64'(4'b1000));
        chk("edge_no_err", 64'({req_err, arb_error}), 0);
        step();

        // Timeout with a stray wr_done while waiting for a read.
        drive_req(0, 1'b0, 32'h40, 16'd4);
        step();
        req_valid = '0;
        rd_cmd_ready = 1'b1;
        step();
        rd_cmd_ready = 1'b0;
        wr_done = 1'b1;
        cnt = 0;
        while (cnt < TO + 16) begin
            step();
            cnt++;
            wr_done = 1'b0;
            if (req_done != '0) break;
        end
        chk("timeout_cycles", 64'(cnt), 64'(TO));
        chk("timeout_done", 64'(req_done), 64'(4'b0001));
        chk("timeout_err", req_err, 1);
        chk("arb_error_set", arb_error, 1);
        step();
        chk("arb_error_sticky", arb_error, 1);
        chk("timeout_idle", 64'({busy, req_err, req_done}), 0);

        // Reset in the middle of a write request.
        drive_req(2, 1'b1, 32'h0, 16'd40);
        step();
        req_valid = '0;
        wr_cmd_ready = 1'b1;
        step();
        wr_cmd_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_outs", 64'({req_ready, req_done, req_err, wr_cmd_valid,
                                 rd_cmd_valid, owner_id, arb_error}), 0);
        chk("mid_rst_addr", 64'({wr_cmd_addr, wr_cmd_len}), 0);
        step();
        wr_done = 1'b1;
        step();
        wr_done = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_no_done", 64'(req_done), 0);

        // All clients valid, len 1: grant order restarts at 0 after reset.
        req_valid = '1;
        req_write = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = 32'(i * 32'h100);
            req_len[i*LW +: LW]  = 16'd1;
        end
        rd_cmd_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 64'(req_ready), 64'(1 << (k % N)));
            step();
            chk("rr_cmd_addr", 64'(rd_cmd_addr), 64'((k % N) * 32'h100));
            step();
            rd_done = 1'b1;
            step();
            rd_done = 1'b0;
            #1;
            chk("rr_done", 64'(req_done), 64'(1 << (k % N)));
            step();
        end
        req_valid = '0;
        rd_cmd_ready = 1'b0;
        step();
        chk("final_idle", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
